switch_debounce_ctrl: RTL and testbench
=======================================

// Module: switch_debounce_ctrl
// PURPOSE
//   Input-side conditioner for the three lamp switches. Synchronises and
//   debounces raw switch levels S_raw[2:0] into clean levels S[2:0] for the
//   lamp logic.
//   Emits one-cycle change pulses and the three-way lamp function
//   F = S1^S2^S3.
//   Optionally drives a timed confirmation beep.
//   Sits between the board switch pins and the lamp/7-seg display logic.
// PARAMETERS
//   DB_CYCLES    500000   stable cycles required to accept a new level (10 ms @ 50 MHz); >=2
//   CNT_W        20       width of each debounce counter; 2**CNT_W > DB_CYCLES
//   BEEP_CYCLES  5000000  Buzzer high time after an accepted change; only used with BEEP_EN
//   BEEP_W       23       width of beep counter; 2**BEEP_W > BEEP_CYCLES
// PORTS
//   clk     in   1  system clock; all state on rising edge
//   rst     in   1  asynchronous, active-high reset
//   S_raw   in   3  raw switch levels, asynchronous to clk; bit0=S1, bit1=S2, bit2=S3
//   S       out  3  debounced switch levels (registered)
//   S_chg   out  3  one-cycle pulse per bit, asserted in the cycle S[i] changes
//   F       out  1  lamp state = S[0]^S[1]^S[2] (combinational from S regs)
//   Buzzer  out  1  beep output; constant 0 when BEEP_EN undefined
// BEHAVIOUR
//   Reset (async, rst=1):
//     - sync flops, S, S_chg, all counters and Buzzer go to 0; F therefore 0.
//     - Reset mid-count discards partial counts; no S_chg pulse is produced.
//   Synchroniser: 2-flop chain per bit; sy[i] = S_raw[i] delayed 2 edges.
//   Debounce, per bit independent:
//     - sy[i]==S[i]: cnt[i] <= 0.
//     - sy[i]!=S[i] and cnt[i]<DB_CYCLES-1: cnt[i] <= cnt[i]+1.
//     - sy[i]!=S[i] and cnt[i]==DB_CYCLES-1: S[i] <= sy[i], cnt[i] <= 0, S_chg[i] <= 1.
//     - S_chg[i] <= 0 in every other cycle.
//   Latency: a clean S_raw step appears on S exactly 2+DB_CYCLES rising
//     edges after the first edge that samples it.
//   Glitches:
//     - Any return to the old level before DB_CYCLES consecutive mismatches
//       clears cnt; S is unchanged and no pulse fires.
//   Simultaneous events:
//     - Several bits may accept in the same cycle; each asserts its own
//       S_chg bit.
//     - F reflects the combined new value in that cycle (two bits flipping
//       together leave F unchanged).
//   Counters never wrap: saturation is structurally prevented by the
//     DB_CYCLES-1 compare.
//   No state machine beyond per-bit IDLE (cnt==0) / COUNTING (cnt>0); COUNTING
//     returns to IDLE on match or on accept.
// CONFIGURATION
//   BEEP_EN defined:
//     - Beep counter bcnt. Any S_chg bit high loads bcnt <= BEEP_CYCLES;
//       otherwise bcnt decrements while nonzero.
//     - Buzzer = (bcnt != 0), registered; rises 1 cycle after the S_chg pulse.
//     - A new change during a beep reloads bcnt (retrigger), extending the beep.
//   BEEP_EN undefined:
//     - No beep counter is built; Buzzer tied to 1'b0.
//     - All other behaviour identical.
// TESTING (bench params DB_CYCLES=4, BEEP_CYCLES=8, BEEP_EN defined)
//   1. Assert rst with S_raw=3'b111 -> S=0, S_chg=0, F=0, Buzzer=0 while rst high.
//   2. After reset, S_raw 000->100 held -> S=100 and S_chg=100 for one cycle
//      exactly 6 edges later; F=1.
//   3. S_raw[0] high for 3 cycles, then low -> S, S_chg, F, Buzzer never change.
//   4. S_raw 000->011 in one cycle -> S=011 after 6 edges, S_chg=011 for one
//      cycle, F stays 0.
//   5. Accepted change, second change accepted 3 cycles after Buzzer rises ->
//      Buzzer stays high continuously, 8 cycles after 2nd pulse, then low.
//   6. S_raw[1] step, rst pulsed after 4 edges, released -> S=000 and no pulse;
//      S[1]=1 only after a further 6 edges.

Source files
------------

// File: rtl/switch_debounce_ctrl.sv
// switch_debounce_ctrl
// Input-side conditioner for the three lamp switches: a 2-flop synchroniser
// and an independent debounce counter per switch. It produces clean levels S,
// one-cycle change pulses S_chg, and the three-way lamp function F.
// Optional feature macro: BEEP_EN. When defined, a retriggerable timer drives
// Buzzer high for BEEP_CYCLES cycles after each accepted change. When
// undefined, no timer is built and Buzzer is tied low.
module switch_debounce_ctrl #(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned BEEP_CYCLES = 5000000,
  parameter int unsigned BEEP_W      = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] S_raw,
  output logic [2:0] S,
  output logic [2:0] S_chg,
  output logic       F,
  output logic       Buzzer
);

  // The counter reaches this value on the last mismatching cycle before the
  // new level is taken. Comparing against it also keeps the counter from
  // ever wrapping.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Reject parameter sets that cannot work: counters too narrow, or a
  // debounce window too short.
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("switch_debounce_ctrl: DB_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
    $error("switch_debounce_ctrl: CNT_W too narrow for DB_CYCLES");
  end
  if ((64'd1 << BEEP_W) <= 64'(BEEP_CYCLES)) begin : g_bad_beep_w
    $error("switch_debounce_ctrl: BEEP_W too narrow for BEEP_CYCLES");
  end

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt [3];

  // Two-flop synchroniser: brings the asynchronous switch pins into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= S_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce each switch independently. A new level is accepted only after
  // DB_CYCLES consecutive mismatches, and a single-cycle pulse marks the change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S     <= 3'b000;
      S_chg <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        S_chg[i] <= 1'b0;
        if (r_sync2[i] == S[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          S[i]     <= r_sync2[i];
          S_chg[i] <= 1'b1;
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign F = ^S;

`ifdef BEEP_EN
  logic [BEEP_W-1:0] r_bcnt;
  logic [BEEP_W-1:0] w_bcnt_next;
  logic              r_buzzer;

  // Next beep count: any change pulse reloads the full duration, which
  // extends a beep already in progress; otherwise the count runs down to zero.
  always_comb begin
    w_bcnt_next = r_bcnt;
    if (|S_chg) begin
      w_bcnt_next = BEEP_W'(BEEP_CYCLES);
    end else if (r_bcnt != '0) begin
      w_bcnt_next = r_bcnt - 1'b1;
    end
  end

  // Register the count and the buzzer level together, so Buzzer rises one
  // cycle after the change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt   <= '0;
      r_buzzer <= 1'b0;
    end else begin
      r_bcnt   <= w_bcnt_next;
      r_buzzer <= (w_bcnt_next != '0);
    end
  end

  assign Buzzer = r_buzzer;
`else
  assign Buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// tb_switch_debounce_ctrl
// Directed scenarios followed by a randomized phase. A behavioural model
// predicts S, S_chg, F and Buzzer, and the bench compares them with the DUT
// on every falling edge. The DUT is built with DB_CYCLES=4 and BEEP_CYCLES=8.
// The Buzzer expectation follows the BEEP_EN macro as the bench sees it.
module tb_switch_debounce_ctrl;

  localparam int DB = 4;
  localparam int CW = 3;
  localparam int BC = 8;
  localparam int BW = 4;
`ifdef BEEP_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [2:0] S_raw = 3'b111;
  logic [2:0] S;
  logic [2:0] S_chg;
  logic       F;
  logic       Buzzer;

  int total = 0;
  int bad   = 0;

  switch_debounce_ctrl #(
    .DB_CYCLES  (DB),
    .CNT_W      (CW),
    .BEEP_CYCLES(BC),
    .BEEP_W     (BW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .S_raw (S_raw),
    .S     (S),
    .S_chg (S_chg),
    .F     (F),
    .Buzzer(Buzzer)
  );

  always #5 clk = ~clk;

  // Model state. delayQ holds the raw samples still travelling through the
  // synchroniser. runLen counts consecutive disagreeing samples for each
  // switch. lastPulse is the edge number at which the last change pulse was
  // visible.
  logic [2:0] delayQ[$];
  logic [2:0] mS        = 3'b000;
  logic [2:0] mChg      = 3'b000;
  logic [2:0] mSy;
  int         runLen[3] = '{0, 0, 0};
  int         edgeNo    = 0;
  int         lastPulse = -1000;

  // Advance the model once per rising edge. Reset wipes all history.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mS        = 3'b000;
      mChg      = 3'b000;
      runLen    = '{0, 0, 0};
      edgeNo    = 0;
      lastPulse = -1000;
      delayQ.delete();
      delayQ.push_back(3'b000);
      delayQ.push_back(3'b000);
    end else begin
      edgeNo++;
      mSy = delayQ.pop_front();
      delayQ.push_back(S_raw);
      mChg = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (mSy[i] != mS[i]) runLen[i]++;
        else runLen[i] = 0;
        if (runLen[i] == DB) begin
          mS[i]     = ~mS[i];
          mChg[i]   = 1'b1;
          runLen[i] = 0;
        end
      end
      if (mChg != 3'b000) lastPulse = edgeNo;
    end
  end

  task automatic checkOutput();
    logic expBuz;
    expBuz = BEEP_ON && ((edgeNo - lastPulse) >= 1) && ((edgeNo - lastPulse) <= BC);
    total++;
    assert (S === mS) else begin
      bad++;
      $error("[TB] FAIL S actual=%b expected=%b edge=%0d", S, mS, edgeNo);
    end
    total++;
    assert (S_chg === mChg) else begin
      bad++;
      $error("[TB] FAIL S_chg actual=%b expected=%b edge=%0d", S_chg, mChg, edgeNo);
    end
    total++;
    assert (F === ^mS) else begin
      bad++;
      $error("[TB] FAIL F actual=%b expected=%b edge=%0d", F, ^mS, edgeNo);
    end
    total++;
    assert (Buzzer === expBuz) else begin
      bad++;
      $error("[TB] FAIL Buzzer actual=%b expected=%b edge=%0d", Buzzer, expBuz, edgeNo);
    end
  endtask

  task automatic checkValue(input string tag, input logic [3:0] act, input logic [3:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("[TB] FAIL %s actual=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic applyStimulus(input logic [2:0] raw, input int n);
    S_raw = raw;
    waitCycles(n);
  endtask

  initial begin
    logic [2:0] nextRaw;

    // 1: reset held with all switches high
    waitCycles(3);
    checkValue("t1_S", {1'b0, S}, 4'b0000);
    checkValue("t1_S_chg", {1'b0, S_chg}, 4'b0000);
    checkValue("t1_F", {3'b000, F}, 4'b0000);
    checkValue("t1_Buzzer", {3'b000, Buzzer}, 4'b0000);

    // 2: clean step on S3, accepted 6 edges after the first sampling edge
    rst = 1'b0;
    applyStimulus(3'b100, 5);
    checkValue("t2_S_early", {1'b0, S}, 4'b0000);
    waitCycles(1);
    checkValue("t2_S", {1'b0, S}, 4'b0100);
    checkValue("t2_S_chg", {1'b0, S_chg}, 4'b0100);
    checkValue("t2_F", {3'b000, F}, 4'b0001);
    waitCycles(1);
    checkValue("t2_S_chg_clear", {1'b0, S_chg}, 4'b0000);

    // 3: short glitch on S1 is ignored
    applyStimulus(3'b101, 3);
    applyStimulus(3'b100, 10);
    checkValue("t3_S", {1'b0, S}, 4'b0100);
    checkValue("t3_F", {3'b000, F}, 4'b0001);

    // 4: two switches flip together, F unchanged
    applyStimulus(3'b000, 12);
    applyStimulus(3'b011, 5);
    waitCycles(1);
    checkValue("t4_S", {1'b0, S}, 4'b0011);
    checkValue("t4_S_chg", {1'b0, S_chg}, 4'b0011);
    checkValue("t4_F", {3'b000, F}, 4'b0000);
    waitCycles(12);
    checkValue("t4_Buzzer_off", {3'b000, Buzzer}, 4'b0000);

    // 5: second change accepted 3 cycles after Buzzer rises retriggers it
    applyStimulus(3'b111, 4);
    applyStimulus(3'b110, 13);
    waitCycles(1);
    checkValue("t5_Buzzer_tail", {3'b000, Buzzer}, {3'b000, BEEP_ON});
    waitCycles(1);
    checkValue("t5_Buzzer_end", {3'b000, Buzzer}, 4'b0000);
    checkValue("t5_S", {1'b0, S}, 4'b0110);

    // 6: reset in mid-count discards progress
    rst = 1'b1;
    S_raw = 3'b000;
    waitCycles(1);
    rst = 1'b0;
    applyStimulus(3'b010, 4);
    rst = 1'b1;
    waitCycles(1);
    checkValue("t6_S_rst", {1'b0, S}, 4'b0000);
    checkValue("t6_S_chg_rst", {1'b0, S_chg}, 4'b0000);
    rst = 1'b0;
    waitCycles(5);
    checkValue("t6_S_early", {1'b0, S}, 4'b0000);
    waitCycles(1);
    checkValue("t6_S", {1'b0, S}, 4'b0010);
    checkValue("t6_S_chg", {1'b0, S_chg}, 4'b0010);

    // Randomized phase: sparse bit flips give both glitches and accepted
    // changes, with an occasional reset
    for (int c = 0; c < 400; c++) begin
      nextRaw = S_raw;
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) nextRaw[b] = ~nextRaw[b];
      end
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        applyStimulus(nextRaw, 1);
        rst = 1'b0;
      end else begin
        applyStimulus(nextRaw, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
